// File: rtl/can_tx_pkg.sv
// can_tx_pkg: shared types and constants for the CAN transmit serializer.
// Defines the state encoding, the stuff-run default and the bus levels.
package can_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_TAIL   = 2'd2
    } tx_state_e;

    localparam int   STUFF_LEN_DEFAULT = 5;
    localparam logic RECESSIVE         = 1'b1;
    localparam logic DOMINANT          = 1'b0;

    // Number of bits carried by a byte; a last byte may be partial, 0 means 8.
    function automatic logic [3:0] byte_len(input logic last,
                                            input logic [2:0] nbits);
        if (last && nbits != 3'd0) begin
            return {1'b0, nbits};
        end
        return 4'd8;
    endfunction

endpackage

// File: rtl/can_tx_bitmon.sv
// can_tx_bitmon: transmit bit monitor, built only with CAN_TX_BITMON_EN.
// Compares the driven bit with the sampled bus bit and flags errors.
`ifdef CAN_TX_BITMON_EN
module can_tx_bitmon
    import can_tx_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic abort,
    input  logic sendpoint,
    input  logic smplpoint,
    input  logic smpldbit,
    input  logic arb_field,
    input  logic tx,
    input  logic busy,
    output logic arb_lose,
    output logic bit_err,
    output logic arb_lost
);

    logic mismatch;

    // A sample coinciding with a send edge is skipped.
    assign mismatch = smplpoint & ~sendpoint & busy & ~abort
                    & (smpldbit != tx);
    assign arb_lose = mismatch & (tx == RECESSIVE)
                    & (smpldbit == DOMINANT) & arb_field;

    // One-cycle error pulses, one clock after the sample point.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_err  <= 1'b0;
            arb_lost <= 1'b0;
        end else begin
            bit_err  <= mismatch & ~arb_lose;
            arb_lost <= arb_lose;
        end
    end

endmodule
`endif

// File: rtl/can_tx_serializer.sv
// can_tx_serializer: CAN transmit bit serializer with bit stuffing.
// Optional bit monitor enabled by defining CAN_TX_BITMON_EN.
module can_tx_serializer
    import can_tx_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sendpoint,
    input  logic       smplpoint,
    input  logic       smpldbit,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic [2:0] tx_nbits,
    input  logic       stuff_en,
    input  logic       arb_field,
    input  logic       abort,
    output logic       tx,
    output logic       done,
    output logic       underrun,
    output logic       bit_err,
    output logic       arb_lost,
    output logic       busy
);

    localparam logic [2:0] STUFF_CMP = 3'(STUFF_LEN);

    tx_state_e  state_q, state_d;
    logic [7:0] shreg, buf_data;
    logic [3:0] bitcnt;
    logic [2:0] buf_nbits, run_cnt, run_next;
    logic       buf_last, buf_full, last_bit, last_seen;
    logic       hs, stuff_bit, data_bit, byte_end;
    logic       fin, reload, starve, arb_lose, flush;

    assign hs        = tx_valid & tx_ready;
    assign stuff_bit = stuff_en & (run_cnt == STUFF_CMP);
    assign data_bit  = (state_q == ST_ACTIVE) & sendpoint & ~stuff_bit;
    assign byte_end  = data_bit & (bitcnt == 4'd1);
    assign fin       = byte_end & last_seen;
    assign reload    = byte_end & ~last_seen & buf_full;
    assign starve    = byte_end & ~last_seen & ~buf_full;
    assign flush     = abort | arb_lose;

`ifdef CAN_TX_BITMON_EN
    can_tx_bitmon u_bitmon (
        .clock     (clock),
        .reset     (reset),
        .abort     (abort),
        .sendpoint (sendpoint),
        .smplpoint (smplpoint),
        .smpldbit  (smpldbit),
        .arb_field (arb_field),
        .tx        (tx),
        .busy      (busy),
        .arb_lose  (arb_lose),
        .bit_err   (bit_err),
        .arb_lost  (arb_lost)
    );
`else
    logic unused_bitmon;
    assign unused_bitmon = smplpoint ^ smpldbit ^ arb_field;
    assign arb_lose      = 1'b0;
    assign bit_err       = 1'b0;
    assign arb_lost      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: abort and lost arbitration win over everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (hs) state_d = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (fin)         state_d = ST_TAIL;
                    else if (starve) state_d = ST_IDLE;
                end
                ST_TAIL:   if (sendpoint & ~stuff_bit) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        tx_ready = ~reset & ~flush
                 & ((state_q == ST_IDLE)
                 | ((state_q == ST_ACTIVE) & ~buf_full & ~last_seen));
    end

    // Run length after a data bit; the first bit of a frame starts at 1.
    always_comb begin
        run_next = 3'd1;
        if (run_cnt != 3'd0 && shreg[7] == last_bit) begin
            run_next = (run_cnt == 3'd7) ? 3'd7 : run_cnt + 3'd1;
        end
    end

    // Datapath: shift register, holding buffer, stuff tracking, tx and pulses.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            tx        <= RECESSIVE;
            shreg     <= 8'd0;
            bitcnt    <= 4'd0;
            buf_data  <= 8'd0;
            buf_last  <= 1'b0;
            buf_nbits <= 3'd0;
            buf_full  <= 1'b0;
            run_cnt   <= 3'd0;
            last_bit  <= RECESSIVE;
            last_seen <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            done     <= fin;
            underrun <= starve;
            unique case (state_q)
                ST_IDLE: begin
                    tx <= RECESSIVE;
                    if (hs) begin
                        shreg     <= tx_data;
                        bitcnt    <= byte_len(tx_last, tx_nbits);
                        last_seen <= tx_last;
                        run_cnt   <= 3'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (sendpoint && stuff_bit) begin
                        tx       <= ~last_bit;
                        last_bit <= ~last_bit;
                        run_cnt  <= 3'd1;
                    end else if (data_bit) begin
                        tx       <= starve ? RECESSIVE : shreg[7];
                        last_bit <= shreg[7];
                        run_cnt  <= run_next;
                        shreg    <= {shreg[6:0], 1'b0};
                        bitcnt   <= bitcnt - 4'd1;
                    end
                    if (reload) begin
                        shreg     <= buf_data;
                        bitcnt    <= byte_len(buf_last, buf_nbits);
                        last_seen <= buf_last;
                        buf_full  <= 1'b0;
                    end
                    if (hs) begin
                        buf_data  <= tx_data;
                        buf_last  <= tx_last;
                        buf_nbits <= tx_nbits;
                        buf_full  <= 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (sendpoint && stuff_bit) begin
                        tx       <= ~last_bit;
                        last_bit <= ~last_bit;
                        run_cnt  <= 3'd1;
                    end else if (sendpoint) begin
                        tx <= RECESSIVE;
                    end
                end
                default: tx <= RECESSIVE;
            endcase
        end
    end

endmodule

// File: doc/can_tx_serializer.md
# can_tx_serializer

Transmit-side bit serializer for the CAN core; the sending counterpart of the bit-timing receive path. It takes frame bytes from the MAC FSM over a valid/ready handshake and shifts them MSB-first onto `tx` at each `sendpoint` pulse from the bit-timing FSM. While the MAC enables stuffing, it inserts CAN stuff bits. An optional bit monitor compares the driven bit with the sampled bus bit at `smplpoint`.

## Interface
- `STUFF_LEN`, default 5: number of equal consecutive bits that triggers a stuff bit.
- `clock` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `sendpoint` in 1: one-cycle pulse from bit timing; drive the next bus bit.
- `smplpoint` in 1: one-cycle pulse from bit timing; bus sample is valid.
- `smpldbit` in 1: sampled bus level, valid when `smplpoint`=1.
- `tx_valid` in 1: byte offered.
- `tx_ready` out 1: byte accepted when `tx_valid`&`tx_ready`.
- `tx_data` in 8: frame bits, MSB first.
- `tx_last` in 1: this byte ends the frame.
- `tx_nbits` in 3: valid bits in the last byte; 0 means 8. Ignored when `tx_last`=0.
- `stuff_en` in 1: stuffing active (SOF..CRC). Sampled at each `sendpoint`.
- `arb_field` in 1: current bit is in the arbitration field.
- `abort` in 1: drop the frame and return to idle.
- `tx` out 1: bus transmit bit; 1 = recessive.
- `done` out 1: pulse when the last frame bit is driven.
- `underrun` out 1: pulse when no byte was available when one was needed.
- `bit_err` out 1: pulse on a bit monitor mismatch.
- `arb_lost` out 1: pulse when arbitration is lost.
- `busy` out 1: frame in progress.

## Operation
- Storage: shift register `shreg[7:0]`, `bitcnt[3:0]` (bits remaining), a one-entry holding buffer (`buf`, `buf_last`, `buf_nbits`, `buf_full`), `run_cnt[2:0]`, `last_bit`, and a `last_seen` flag for the byte in `shreg`.
- States:
  - IDLE: `tx`=1, `busy`=0.
  - ACTIVE: frame bits are being shifted.
  - TAIL: final data bit driven; a trailing stuff bit may still be owed.
- IDLE, `tx_valid`=1 (`tx_ready`=1): the byte loads directly into `shreg`; go to ACTIVE. `tx` stays 1 until the first `sendpoint`.
- ACTIVE, `sendpoint`:
  - If `stuff_en` and `run_cnt`==`STUFF_LEN`: drive `~last_bit`, set `run_cnt`=1, invert `last_bit`. No data bit is consumed.
  - Otherwise: drive `shreg[7]`. `run_cnt` becomes `run_cnt`+1 if the bit equals `last_bit`, else 1. Update `last_bit`, shift left, decrement `bitcnt`.
  - The first data bit of a frame always sets `run_cnt`=1.
- When `bitcnt` reaches 0 on a data bit:
  - If `last_seen`: pulse `done`, go to TAIL.
  - Else if `buf_full`: move the buffer into `shreg` in the same cycle.
  - Else: pulse `underrun`, set `tx`=1, go to IDLE.
- TAIL, next `sendpoint`:
  - If `stuff_en` and `run_cnt`==`STUFF_LEN`: drive the stuff bit; go to IDLE at the following `sendpoint`.
  - Otherwise: `tx`=1, go to IDLE.
- `tx_ready` = (state==IDLE) | (state==ACTIVE & ~`buf_full` & ~`last_seen`).
- `abort` (any state): next cycle `tx`=1, state IDLE, buffer cleared, counters zeroed. `abort` has priority over a handshake and over `sendpoint` in the same cycle; `tx_ready` is 0 while `abort`=1.
- A handshake in the same cycle as a reload: the reload takes the old buffer, then the new byte fills the buffer.

## Timing
- `tx` is registered and changes in the cycle after `sendpoint`, so latency is 1 clock.
- `done`, `underrun`, `bit_err`, `arb_lost` are registered one-cycle pulses, one clock after the causing `sendpoint`/`smplpoint`.
- Reset values: `tx`=1, `tx_ready`=0 during reset and 1 in the cycle after; `done`=`underrun`=`bit_err`=`arb_lost`=`busy`=0; state IDLE.
- `sendpoint` and `smplpoint` never coincide. If they do, `sendpoint` is processed and the monitor skips that sample.

## Configuration
- `CAN_TX_BITMON_EN` defined: at `smplpoint` while `busy`, compare `smpldbit` with `tx`:
  - `tx`=1, `smpldbit`=0, `arb_field`=1: pulse `arb_lost`, set `tx`=1, go to IDLE, clear the buffer.
  - Any other mismatch, stuff bits included: pulse `bit_err`; transmission continues and the MAC decides whether to abort.
- Not defined: `bit_err`=`arb_lost`=0 constantly; `smpldbit` and `arb_field` are unused.

## Structure
- Package `can_tx_pkg`: state encoding (IDLE/ACTIVE/TAIL), `STUFF_LEN_DEFAULT`=5, recessive/dominant level constants.
- Sub-module `can_tx_bitmon`, compiled under the macro: compare logic and pulse registers.

## Test plan
- Frame bytes 0x55, 0x80 (last, `nbits`=8), `stuff_en`=1 → `tx` sequence 01010101 10000000 with a stuff 1 after the 5th 0 of the second byte (1,0,0,0,0,0,**1**,0,0); `done` on the 16th data bit.
- Byte 0x00, last, `nbits`=5, `stuff_en`=1 → 00000 then a TAIL stuff 1, then idle `tx`=1.
- Same stimulus with `stuff_en`=0 → no stuff bit; `run_cnt` ignored.
- Two bytes with the second `tx_valid` withheld past the 8th `sendpoint` → `underrun` pulse, `tx`=1, `busy`=0.
- `abort` together with `tx_valid` mid-byte → `tx_ready`=0, next cycle `tx`=1, state IDLE.
- With the macro: drive `tx`=1 with `smpldbit`=0 and `arb_field`=1 → `arb_lost` pulse and IDLE. Same with `arb_field`=0 → `bit_err` only, transmission continues.
